// File: rtl/logdrop_unwindow_if.sv
// Sample stream bundle for logdrop_unwindow.
// Upstream side: i_valid / i_y in, o_ready back.
// Downstream side: o_valid / o_x / o_t / o_sat / o_last out, i_ready back.
// The block itself uses the slave modport. A driver or bench uses master.
interface logdrop_unwindow_if #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 32
);
  localparam int WINLEN_W = $clog2(WINLEN);

  logic                i_valid;
  logic                o_ready;
  logic [DATA_W-1:0]   i_y;
  logic                o_valid;
  logic                i_ready;
  logic [DATA_W-1:0]   o_x;
  logic [WINLEN_W-1:0] o_t;
  logic                o_sat;
  logic                o_last;

  modport master (
    output i_valid, i_y, i_ready,
    input  o_ready, o_valid, o_x, o_t, o_sat, o_last
  );

  modport slave (
    input  i_valid, i_y, i_ready,
    output o_ready, o_valid, o_x, o_t, o_sat, o_last
  );
endinterface

// File: rtl/logdrop_unwindow.sv
// logdrop_unwindow: undoes the logdrop power-of-two window.
// The block owns the window index t. For each accepted sample y it
// produces x = y * 2^s(t) in the fx domain, saturating to all-ones.
// The result goes into a single registered output stage.
// Ports:
//   i_clk, i_rst : clock and asynchronous active-high reset
//   i_clear      : synchronous restart of the index and the output stage
//   bus (slave)  : i_valid/o_ready/i_y input stream;
//                  o_valid/i_ready/o_x/o_t/o_sat/o_last output stream
module logdrop_unwindow #(
  parameter int DATA_W = 8,
  parameter int WINLEN = 32
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clear,
  logdrop_unwindow_if.slave   bus
);
  localparam int WINLEN_W = $clog2(WINLEN);
  localparam logic [DATA_W-1:0] ALL1 = '1;

  logic [WINLEN_W-1:0] t_q;
  logic [WINLEN_W-1:0] a;
  logic [WINLEN_W-1:0] lg;
  logic [WINLEN_W-1:0] s;
  logic [DATA_W-1:0]   fill;
  logic [DATA_W-1:0]   x_d;
  logic                sat_d;
  logic                accept;

  // Shift amount. The window is symmetric, so fold t onto the distance a
  // from the nearer edge (~t for the upper half). Then take floor(log2 a).
  always_comb begin
    a  = t_q[WINLEN_W-1] ? ~t_q : t_q;
    lg = '0;
    for (int unsigned i = 0; i < WINLEN_W; i++) begin
      if (a[i]) lg = WINLEN_W'(i);
    end
    if (a >= WINLEN_W'(WINLEN / 4))
      s = '0;
    else if (a == '0)
      s = WINLEN_W'(WINLEN_W - 1);
    else
      s = WINLEN_W'(WINLEN_W - 2) - lg;
  end

  // fx value v stands for (v+1)/2^DATA_W. The vacated LSBs therefore
  // fill with ones. Any set bit in the top s bits of y would shift out,
  // so the result saturates.
  always_comb begin
    fill  = ~(ALL1 << s);
    sat_d = |(bus.i_y & ~(ALL1 >> s));
    x_d   = sat_d ? ALL1 : ((bus.i_y << s) | fill);
  end

  assign bus.o_ready = !i_rst && !i_clear && (!bus.o_valid || bus.i_ready);
  assign accept      = bus.i_valid && bus.o_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      t_q        <= '0;
      bus.o_valid <= 1'b0;
      bus.o_x    <= '0;
      bus.o_t    <= '0;
      bus.o_sat  <= 1'b0;
      bus.o_last <= 1'b0;
    end else if (i_clear) begin
      t_q         <= '0;
      bus.o_valid <= 1'b0;
    end else if (accept) begin
      t_q         <= t_q + WINLEN_W'(1);
      bus.o_valid <= 1'b1;
      bus.o_x     <= x_d;
      bus.o_sat   <= sat_d;
      bus.o_t     <= t_q;
      bus.o_last  <= (t_q == '1);
    end else if (bus.o_valid && bus.i_ready) begin
      bus.o_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_logdrop_unwindow.sv
module tb_logdrop_unwindow;
  localparam int DATA_W   = 8;
  localparam int WINLEN   = 16;
  localparam int WINLEN_W = 4;
  localparam int XMAX     = (1 << DATA_W) - 1;

  logic i_clk = 1'b0;
  logic i_rst;
  logic i_clear;

  logdrop_unwindow_if #(.DATA_W(DATA_W), .WINLEN(WINLEN)) bus ();

  logdrop_unwindow #(.DATA_W(DATA_W), .WINLEN(WINLEN)) dut (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_clear (i_clear),
    .bus     (bus)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int x;
    int sat;
    int t;
    int last;
  } exp_t;

  exp_t q[$];
  int   mt;
  int   n_cmp;
  int   n_fail;

  // Window shift from the distance to the nearer window edge.
  function automatic int shift_of(input int t);
    int a;
    int lg;
    a  = (t < WINLEN - 1 - t) ? t : WINLEN - 1 - t;
    lg = 0;
    if (a >= WINLEN / 4) return 0;
    if (a == 0) return WINLEN_W - 1;
    while ((a >> (lg + 1)) != 0) lg++;
    return WINLEN_W - 2 - lg;
  endfunction

  // Arithmetic view: x = y*2^s + (2^s - 1), clipped at full scale.
  function automatic exp_t model_out(input int y, input int t);
    int   s;
    int   v;
    exp_t e;
    s      = shift_of(t);
    v      = y * (1 << s) + (1 << s) - 1;
    e.sat  = (v > XMAX) ? 1 : 0;
    e.x    = (v > XMAX) ? XMAX : v;
    e.t    = t;
    e.last = (t == WINLEN - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit v, input logic [7:0] y, input bit r, input bit c);
    bus.i_valid = v;
    bus.i_y     = y;
    bus.i_ready = r;
    i_clear     = c;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "/valid"}, 32'(bus.o_valid), 0);
    check({tag, "/x"},     32'(bus.o_x),     0);
    check({tag, "/t"},     32'(bus.o_t),     0);
    check({tag, "/sat"},   32'(bus.o_sat),   0);
    check({tag, "/last"},  32'(bus.o_last),  0);
    check({tag, "/ready"}, 32'(bus.o_ready), 0);
  endtask

  // One clock: check o_ready before the edge, advance the scoreboard at
  // the edge, then compare the output stage with the expected head.
  task automatic cycle(input string tag);
    bit   clr;
    bit   rdy;
    bit   acc;
    bit   drn;
    int   y;
    #1;
    clr = i_clear;
    rdy = !clr && (q.size() == 0 || bus.i_ready);
    acc = bus.i_valid && rdy;
    drn = (q.size() != 0) && bus.i_ready;
    y   = int'(bus.i_y);
    check({tag, "/o_ready"}, 32'(bus.o_ready), 32'(rdy));
    @(posedge i_clk);
    #1;
    if (clr) begin
      q.delete();
      mt = 0;
    end else begin
      if (drn) void'(q.pop_front());
      if (acc) begin
        q.push_back(model_out(y, mt));
        mt = (mt + 1) % WINLEN;
      end
    end
    check({tag, "/o_valid"}, 32'(bus.o_valid), 32'(q.size() != 0));
    if (q.size() != 0) begin
      check({tag, "/o_x"},    32'(bus.o_x),    q[0].x);
      check({tag, "/o_sat"},  32'(bus.o_sat),  q[0].sat);
      check({tag, "/o_t"},    32'(bus.o_t),    q[0].t);
      check({tag, "/o_last"}, 32'(bus.o_last), q[0].last);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    mt     = 0;
    i_rst  = 1'b1;
    drive(0, 8'h00, 1, 0);
    #2;
    check_reset("por");
    repeat (2) @(posedge i_clk);
    #3;
    i_rst = 1'b0;

    // First sample at t=0.
    drive(1, 8'h0F, 1, 0);
    cycle("p1");
    check("p1_x",   32'(bus.o_x),     32'h7F);
    check("p1_sat", 32'(bus.o_sat),   0);
    check("p1_t",   32'(bus.o_t),     0);
    check("p1_v",   32'(bus.o_valid), 1);

    // Saturation and pass-through.
    drive(0, 8'h00, 1, 1);
    cycle("clr_a");
    drive(1, 8'h20, 1, 0);
    cycle("p2_t0");
    check("p2_t0_x",   32'(bus.o_x),   32'hFF);
    check("p2_t0_sat", 32'(bus.o_sat), 1);
    drive(1, 8'h3F, 1, 0);
    cycle("p2_t1");
    check("p2_t1_x",   32'(bus.o_x),   32'hFF);
    check("p2_t1_sat", 32'(bus.o_sat), 0);
    for (int i = 2; i < 5; i++) begin
      drive(1, 8'($urandom), 1, 0);
      cycle("p2_fill");
    end
    drive(1, 8'hA5, 1, 0);
    cycle("p2_t5");
    check("p2_t5_x", 32'(bus.o_x), 32'hA5);
    check("p2_t5_t", 32'(bus.o_t), 5);

    // Round trip through the forward window, 17 samples from t=0.
    drive(0, 8'h00, 1, 1);
    cycle("clr_b");
    for (int i = 0; i < 17; i++) begin
      drive(1, 8'(8'hB7 >> shift_of(mt)), 1, 0);
      cycle("rt");
      check("rt_x",    32'(bus.o_x),    32'hB7);
      check("rt_last", 32'(bus.o_last), 32'(i == 15));
      check("rt_t",    32'(bus.o_t),    32'(i % 16));
    end

    // Backpressure: stall three cycles, then drain at full rate.
    drive(0, 8'h00, 1, 1);
    cycle("clr_c");
    drive(1, 8'h11, 0, 0);
    cycle("bp_acc");
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), 0, 0);
      cycle("bp_stall");
      check("bp_hold_x", 32'(bus.o_x), 32'h8F);
      check("bp_hold_t", 32'(bus.o_t), 0);
    end
    for (int i = 0; i < 5; i++) begin
      drive(1, 8'($urandom), 1, 0);
      cycle("bp_run");
    end
    check("bp_run_t", 32'(bus.o_t), 5);

    // Clear at t=9 drops the presented sample.
    drive(0, 8'h00, 1, 1);
    cycle("clr_d");
    for (int i = 0; i < 9; i++) begin
      drive(1, 8'($urandom), 1, 0);
      cycle("pre9");
    end
    drive(1, 8'h55, 1, 1);
    cycle("clr9");
    check("clr9_v", 32'(bus.o_valid), 0);
    drive(1, 8'h05, 1, 0);
    cycle("post9");
    check("post9_t", 32'(bus.o_t), 0);
    check("post9_x", 32'(bus.o_x), 32'h2F);

    // Asynchronous reset mid-window with a pending output.
    for (int i = 0; i < 3; i++) begin
      drive(1, 8'($urandom), 0, 0);
      cycle("pre_rst");
    end
    #3;
    i_rst = 1'b1;
    #1;
    check_reset("arst");
    q.delete();
    mt = 0;
    #1;
    i_rst = 1'b0;
    drive(1, 8'h01, 1, 0);
    cycle("post_rst");
    check("post_rst_t", 32'(bus.o_t), 0);
    check("post_rst_x", 32'(bus.o_x), 32'h0F);

    // Randomized traffic against the scoreboard.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
      cycle("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
